spi_adc_responder: RTL and testbench

Synthesizable SPI slave that emulates a dual-channel 12-bit ADC (MCP3202-style framing) so the car simulator's SPI ADC master can be exercised from on-board sources: a second FPGA, DIP-switch presets or a test pattern generator. It sits on the far end of the SCK/CS_N/MOSI/MISO bundle the ADC master drives. It oversamples all SPI pins in the system clock domain and returns the latched accelerator (CH0) and CDS (CH1) values. It also reports frame completion, aborts and channel usage.

---
 rtl/spi_adc_responder.sv | 181 ++++++++++++++++++
 tb/tb_spi_adc_responder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/spi_adc_responder.sv
// SPI slave emulating a dual-channel MCP3202-style ADC, oversampled in the clk domain.
// Returns ch0_val/ch1_val (single-ended) or a saturated pseudo-differential result.
module spi_adc_responder #(
  parameter int DATA_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  input  logic [DATA_W-1:0] ch0_val,
  input  logic [DATA_W-1:0] ch1_val,
  output logic              frame_done,
  output logic              frame_abort,
  output logic              last_ch,
  output logic [7:0]        frame_cnt
);

  // state   | meaning
  // S_IDLE  | CS_N high, MISO low
  // S_START | waiting for the start bit, skipping leading zeros
  // S_CFG   | shifting in SGL/DIFF, ODD/SIGN, MSBF
  // S_NULL  | next SCK fall latches result and drives the null bit
  // S_DATA  | shifting the result out MSB first
  // S_TAIL  | frame complete, MISO low until CS_N rises
  typedef enum logic [2:0] {S_IDLE, S_START, S_CFG, S_NULL, S_DATA, S_TAIL} state_t;

  localparam int CW = $clog2(DATA_W + 1);

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic sck_d, cs_d;
  logic sck_s, cs_s, mosi_s;
  logic sck_rise, sck_fall, cs_fall, cs_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sck_d     <= sck_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_fall  = ~cs_s & cs_d;
  assign cs_rise  = cs_s & ~cs_d;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sgl_q, sgl_d, odd_q, odd_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              miso_q, miso_d;
  logic              done_q, done_d, abort_q, abort_d;
  logic              last_ch_q, last_ch_d;
  logic [7:0]        fcnt_q, fcnt_d;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] result;

  // Pseudo-differential: borrow out of the extended subtract means negative, clamp to 0.
  always_comb begin
    diff = odd_q ? ({1'b0, ch1_val} - {1'b0, ch0_val})
                 : ({1'b0, ch0_val} - {1'b0, ch1_val});
    if (sgl_q)
      result = odd_q ? ch1_val : ch0_val;
    else
      result = diff[DATA_W] ? '0 : diff[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sgl_q     <= 1'b0;
      odd_q     <= 1'b0;
      shreg_q   <= '0;
      miso_q    <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      last_ch_q <= 1'b0;
      fcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sgl_q     <= sgl_d;
      odd_q     <= odd_d;
      shreg_q   <= shreg_d;
      miso_q    <= miso_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
      last_ch_q <= last_ch_d;
      fcnt_q    <= fcnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sgl_d     = sgl_q;
    odd_d     = odd_q;
    shreg_d   = shreg_q;
    miso_d    = miso_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    last_ch_d = last_ch_q;
    fcnt_d    = fcnt_q;
    // A new select always restarts the frame, even if the previous CS_N rise was missed.
    if (cs_fall) begin
      state_d = S_START;
      cnt_d   = '0;
      miso_d  = 1'b0;
    end else if (cs_rise) begin
      if (state_q != S_IDLE && state_q != S_TAIL) abort_d = 1'b1;
      state_d = S_IDLE;
      miso_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: miso_d = 1'b0;
        S_START: begin
          if (sck_rise && mosi_s) begin
            state_d = S_CFG;
            cnt_d   = '0;
          end
        end
        S_CFG: begin
          if (sck_rise) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(0)) sgl_d = mosi_s;
            if (cnt_q == CW'(1)) odd_d = mosi_s;
            if (cnt_q == CW'(2)) state_d = S_NULL;
          end
        end
        S_NULL: begin
          if (sck_fall) begin
            shreg_d   = result;
            miso_d    = 1'b0;
            last_ch_d = odd_q;
            cnt_d     = '0;
            state_d   = S_DATA;
          end
        end
        S_DATA: begin
          if (sck_fall && cnt_q < CW'(DATA_W)) begin
            miso_d  = shreg_q[DATA_W-1];
            shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
            cnt_d   = cnt_q + CW'(1);
          end else if (sck_rise && cnt_q == CW'(DATA_W)) begin
            done_d  = 1'b1;
            fcnt_d  = fcnt_q + 8'd1;
            miso_d  = 1'b0;
            state_d = S_TAIL;
          end
        end
        S_TAIL: miso_d = 1'b0;
        default: begin
          state_d = S_IDLE;
          miso_d  = 1'b0;
        end
      endcase
    end
  end

  assign spi_miso    = miso_q;
  assign frame_done  = done_q;
  assign frame_abort = abort_q;
  assign last_ch     = last_ch_q;
  assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Bench for spi_adc_responder: bit-banged SPI master with an expected-word scoreboard.
module tb_spi_adc_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_sck = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic [11:0] ch0_val = '0;
  logic [11:0] ch1_val = '0;
  logic        frame_done, frame_abort, last_ch;
  logic [7:0]  frame_cnt;

  spi_adc_responder #(.DATA_W(12), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .ch0_val(ch0_val), .ch1_val(ch1_val), .frame_done(frame_done),
    .frame_abort(frame_abort), .last_ch(last_ch), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int done_pulses = 0;
  int abort_pulses = 0;
  int pulse_errs = 0;
  logic prev_done = 1'b0, prev_abort = 1'b0;
  logic [11:0] exp_q[$];

  always @(negedge clk) begin
    if (frame_done) done_pulses++;
    if (frame_abort) abort_pulses++;
    if ((frame_done && frame_abort) || (frame_done && prev_done) || (frame_abort && prev_abort))
      pulse_errs++;
    prev_done  <= frame_done;
    prev_abort <= frame_abort;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [11:0] model(input bit sgl, input bit odd,
                                         input logic [11:0] c0, input logic [11:0] c1);
    int d;
    if (sgl) return odd ? c1 : c0;
    d = odd ? (int'(c1) - int'(c0)) : (int'(c0) - int'(c1));
    return (d < 0) ? 12'h000 : 12'(d);
  endfunction

  // stop_after < 0: full frame. Otherwise stop after that many data bits;
  // hold_cs leaves CS_N low at that point.
  task automatic run_frame(input bit sgl, input bit odd, input int lz, input int stop_after,
                           input bit hold_cs, input int phase, input int chg_at,
                           output logic [11:0] word, output logic null_bit);
    int ncyc = lz + 4 + 1 + 12;
    int nd = 0;
    logic b;
    word = '0;
    null_bit = 1'b1;
    spi_cs_n = 1'b0;
    repeat (phase) @(posedge clk);
    for (int i = 0; i < ncyc; i++) begin
      if (i < lz) b = 1'b0;
      else if (i == lz) b = 1'b1;
      else if (i == lz + 1) b = sgl;
      else if (i == lz + 2) b = odd;
      else if (i == lz + 3) b = 1'b1;
      else b = 1'b0;
      spi_mosi = b;
      repeat (phase) @(posedge clk);
      spi_sck = 1'b1;
      if (i == lz + 4) null_bit = spi_miso;
      if (i > lz + 4) begin
        word = {word[10:0], spi_miso};
        nd++;
        if (nd == chg_at) ch0_val = 12'hFFF;
      end
      repeat (phase) @(posedge clk);
      spi_sck = 1'b0;
      if (stop_after >= 0 && nd == stop_after) break;
    end
    repeat (phase) @(posedge clk);
    if (!hold_cs) spi_cs_n = 1'b1;
    repeat (phase) @(posedge clk);
  endtask

  task automatic full(input bit sgl, input bit odd, input int lz, input int phase,
                      input int chg_at, input string tag);
    logic [11:0] w, e;
    logic nb;
    int d0 = done_pulses;
    exp_q.push_back(model(sgl, odd, ch0_val, ch1_val));
    run_frame(sgl, odd, lz, -1, 1'b0, phase, chg_at, w, nb);
    e = exp_q.pop_front();
    check({tag, "_word"}, 32'(w), 32'(e));
    check({tag, "_done"}, 32'(done_pulses - d0), 32'd1);
  endtask

  initial begin
    logic [11:0] w;
    logic nb;
    int a0, d0;
    bit s, o;

    repeat (3) @(posedge clk);
    #1;
    check("rst_miso", 32'(spi_miso), 0);
    check("rst_cnt", 32'(frame_cnt), 0);
    check("rst_last", 32'(last_ch), 0);
    check("rst_done", 32'(frame_done), 0);
    rst = 1'b0;
    repeat (4) @(posedge clk);

    ch0_val = 12'hA5C;
    exp_q.push_back(12'hA5C);
    d0 = done_pulses;
    run_frame(1'b1, 1'b0, 0, -1, 1'b0, 16, 0, w, nb);
    check("t1_null", 32'(nb), 0);
    check("t1_word", 32'(w), 32'(exp_q.pop_front()));
    check("t1_done", 32'(done_pulses - d0), 1);
    check("t1_cnt", 32'(frame_cnt), 1);
    check("t1_last", 32'(last_ch), 0);

    ch1_val = 12'h0FF;
    full(1'b1, 1'b1, 3, 16, 0, "t2");
    check("t2_last", 32'(last_ch), 1);

    ch0_val = 12'h100; ch1_val = 12'h200;
    full(1'b0, 1'b0, 0, 16, 0, "t3_sat");
    full(1'b0, 1'b1, 0, 16, 0, "t4_diff");
    check("t4_cnt", 32'(frame_cnt), 4);

    a0 = abort_pulses; d0 = done_pulses;
    run_frame(1'b1, 1'b1, 0, 6, 1'b0, 16, 0, w, nb);
    check("ab_pulse", 32'(abort_pulses - a0), 1);
    check("ab_nodone", 32'(done_pulses - d0), 0);
    check("ab_cnt", 32'(frame_cnt), 4);
    check("ab_miso", 32'(spi_miso), 0);
    check("ab_last", 32'(last_ch), 1);
    full(1'b1, 1'b0, 1, 16, 0, "ab_next");
    check("ab_next_cnt", 32'(frame_cnt), 5);

    ch0_val = 12'h123;
    full(1'b1, 1'b0, 0, 16, 3, "chg");
    check("chg_cnt", 32'(frame_cnt), 6);

    ch1_val = 12'hFFF;
    a0 = abort_pulses;
    run_frame(1'b1, 1'b1, 0, 4, 1'b1, 16, 0, w, nb);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mrst_cnt", 32'(frame_cnt), 0);
    check("mrst_last", 32'(last_ch), 0);
    check("mrst_miso", 32'(spi_miso), 0);
    spi_cs_n = 1'b1;
    spi_sck = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    repeat (10) @(posedge clk);
    check("mrst_noabort", 32'(abort_pulses - a0), 0);

    d0 = done_pulses;
    for (int k = 0; k < 256; k++) begin
      s = 1'($urandom_range(0, 1));
      o = 1'($urandom_range(0, 1));
      ch0_val = 12'($urandom_range(0, 4095));
      ch1_val = 12'($urandom_range(0, 4095));
      exp_q.push_back(model(s, o, ch0_val, ch1_val));
      run_frame(s, o, 0, -1, 1'b0, 8, 0, w, nb);
      check("rnd_word", 32'(w), 32'(exp_q.pop_front()));
      if (k == 254) check("rnd_cnt255", 32'(frame_cnt), 255);
    end
    check("wrap_cnt", 32'(frame_cnt), 0);
    check("rnd_done", 32'(done_pulses - d0), 256);
    check("pulse_shape", 32'(pulse_errs), 0);
    check("queue_empty", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
